// File: rtl/adder_operand_loader.sv
// adder_operand_loader: assembles two OP_W-bit adder operands from a DATA_W-bit beat stream,
// holds them stable for HOLD_CYCLES, then pulses res_valid for one cycle.
module adder_operand_loader #(
    parameter int DATA_W      = 64,
    parameter int OP_W        = 1024,
    parameter int HOLD_CYCLES = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 abort,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_W-1:0]                    s_data,
    output logic [OP_W-1:0]                      in1,
    output logic [OP_W-1:0]                      in2,
    output logic                                 op_valid,
    output logic                                 res_valid,
    output logic [$clog2(2*OP_W/DATA_W)-1:0]     beat_cnt
);
    localparam int N  = OP_W / DATA_W;
    localparam int CW = $clog2(2 * OP_W / DATA_W);

    typedef enum logic [1:0] {LOAD, HOLD, RES} state_t;

    state_t     state;
    logic [7:0] hold_cnt;
    logic       accept;
    logic       last;

    assign accept = s_valid && s_ready && !abort;
    assign last   = beat_cnt == CW'(2 * N - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            beat_cnt  <= '0;
            hold_cnt  <= '0;
            s_ready   <= 1'b1;
            op_valid  <= 1'b0;
            res_valid <= 1'b0;
            in1       <= '0;
            in2       <= '0;
        end else if (abort) begin
            // operands are deliberately left untouched on abort
            state     <= LOAD;
            beat_cnt  <= '0;
            s_ready   <= 1'b1;
            op_valid  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: if (accept) begin
                    // beat k lands in in1 chunk k, beat N+k in in2 chunk k (little-endian)
                    for (int k = 0; k < N; k++) begin
                        if (beat_cnt == CW'(k)) in1[k*DATA_W +: DATA_W] <= s_data;
                        if (beat_cnt == CW'(N + k)) in2[k*DATA_W +: DATA_W] <= s_data;
                    end
                    beat_cnt <= last ? '0 : beat_cnt + 1'b1;
                    if (last) begin
                        state    <= HOLD;
                        hold_cnt <= 8'(HOLD_CYCLES - 1);
                        s_ready  <= 1'b0;
                        op_valid <= 1'b1;
                    end
                end
                HOLD: if (hold_cnt == '0) begin
                    state     <= RES;
                    res_valid <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
                RES: begin
                    state     <= LOAD;
                    s_ready   <= 1'b1;
                    op_valid  <= 1'b0;
                    res_valid <= 1'b0;
                end
                default: begin
                    state     <= LOAD;
                    s_ready   <= 1'b1;
                    op_valid  <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_operand_loader.sv
// tb_adder_operand_loader: scoreboard bench for adder_operand_loader (HOLD_CYCLES=6 and =1 builds).
module tb_adder_operand_loader;
    typedef struct packed {
        logic [1023:0] a;
        logic [1023:0] b;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [63:0]   s_data = '0;
    logic          s_ready, op_valid, res_valid;
    logic [1023:0] in1, in2;
    logic [4:0]    beat_cnt;

    logic          abort_h1 = 1'b0;
    logic          s_valid_h1 = 1'b0;
    logic [63:0]   s_data_h1 = '0;
    logic          s_ready_h1, op_valid_h1, res_valid_h1;
    logic [1023:0] in1_h1, in2_h1;
    logic [4:0]    beat_cnt_h1;

    txn_t          exp_q[$];
    logic [1023:0] m1 = '0;
    logic [1023:0] m2 = '0;
    int            passed = 0;
    int            total = 0;
    int            cyc = 0;

    adder_operand_loader dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .in1(in1), .in2(in2), .op_valid(op_valid), .res_valid(res_valid),
        .beat_cnt(beat_cnt)
    );

    adder_operand_loader #(.HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .abort(abort_h1), .s_valid(s_valid_h1), .s_ready(s_ready_h1),
        .s_data(s_data_h1), .in1(in1_h1), .in2(in2_h1), .op_valid(op_valid_h1),
        .res_valid(res_valid_h1), .beat_cnt(beat_cnt_h1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int diff_chunk(input logic [2047:0] x, input logic [2047:0] y);
        for (int i = 0; i < 32; i++) if (x[i*64 +: 64] !== y[i*64 +: 64]) return i;
        return 0;
    endfunction

    function automatic logic [1023:0] rnd();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_beat(input int k, input logic [63:0] d);
        total++;
        if (beat_cnt !== 5'(k)) $display("FAIL beat_cnt_before_beat: got %0d want %0d", beat_cnt, k);
        else passed++;
        s_valid = 1'b1;
        s_data  = d;
        if (k < 16) m1[k*64 +: 64] = d; else m2[(k-16)*64 +: 64] = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_txn(input logic [1023:0] a, input logic [1023:0] b, input bit gapped);
        exp_q.push_back({a, b});
        for (int k = 0; k < 32; k++) begin
            if (gapped && k > 0) @(negedge clk);
            drive_beat(k, k < 16 ? a[k*64 +: 64] : b[(k-16)*64 +: 64]);
        end
    endtask

    task automatic wait_res(output int n);
        n = 1;
        while (res_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (res_valid !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (in1 !== '0 || in2 !== '0) $display("FAIL reset_operands: got in1[63:0]=%h in2[63:0]=%h want 0", in1[63:0], in2[63:0]);
        else passed++;
        total++;
        if (beat_cnt !== 5'd0) $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt);
        else passed++;
        total++;
        if ({op_valid, res_valid, s_ready} !== 3'b001) $display("FAIL reset_flags: got %b want 001", {op_valid, res_valid, s_ready});
        else passed++;
        total++;
        if ({op_valid_h1, res_valid_h1, s_ready_h1} !== 3'b001) $display("FAIL reset_flags_h1: got %b want 001", {op_valid_h1, res_valid_h1, s_ready_h1});
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1023:0] a, b;
        logic [1024:0] sum;
        logic [2047:0] g, w;
        txn_t t;
        int d;
        a = '1;
        b = '0;
        b[0] = 1'b1;
        send_txn(a, b, 1'b0);
        s_valid = 1'b1;
        s_data  = 64'hDEAD_BEEF_0BAD_F00D;
        for (int c = 1; c <= 7; c++) begin
            total++;
            if ({op_valid, res_valid, s_ready} !== {1'b1, c == 7, 1'b0})
                $display("FAIL b2b_flags_cycle%0d: got %b want %b", c, {op_valid, res_valid, s_ready}, {1'b1, c == 7, 1'b0});
            else passed++;
            if (c < 7) @(negedge clk);
        end
        t = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        g = {in1, in2};
        w = {t.a, t.b};
        total++;
        if (g !== w) begin
            d = diff_chunk(g, w);
            $display("FAIL b2b_operands: chunk %0d got %h want %h", d, g[d*64 +: 64], w[d*64 +: 64]);
        end else passed++;
        sum = {1'b0, in1} + {1'b0, in2};
        total++;
        if (sum !== {1'b1, 1024'b0}) $display("FAIL b2b_sum: got carry=%b out[63:0]=%h want carry=1 out=0", sum[1024], sum[63:0]);
        else passed++;
        total++;
        if (beat_cnt !== 5'd0) $display("FAIL b2b_beat_cnt_wrap: got %0d want 0", beat_cnt);
        else passed++;
        @(negedge clk);
        s_valid = 1'b0;
        total++;
        if ({op_valid, res_valid, s_ready} !== 3'b001) $display("FAIL b2b_after_res_flags: got %b want 001", {op_valid, res_valid, s_ready});
        else passed++;
        total++;
        if ({in1, in2} !== w || beat_cnt !== 5'd0) $display("FAIL b2b_no_accept_in_hold: got beat_cnt=%0d in1[63:0]=%h want 0 %h", beat_cnt, in1[63:0], w[1087:1024]);
        else passed++;
    endtask

    task automatic test_gapped();
        logic [2047:0] g, w;
        txn_t t;
        int start, n, d;
        start = cyc;
        send_txn(1024'd5, 1024'd7, 1'b1);
        total++;
        if (cyc - start !== 63) $display("FAIL gapped_load_cycles: got %0d want 63", cyc - start);
        else passed++;
        wait_res(n);
        total++;
        if (n !== 7) $display("FAIL gapped_latency: got %0d want 7", n);
        else passed++;
        t = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        g = {in1, in2};
        w = {t.a, t.b};
        total++;
        if (g !== w) begin
            d = diff_chunk(g, w);
            $display("FAIL gapped_operands: chunk %0d got %h want %h", d, g[d*64 +: 64], w[d*64 +: 64]);
        end else passed++;
        @(negedge clk);
    endtask

    task automatic test_abort_mid_load();
        logic [2047:0] g, w;
        txn_t t;
        int n, d;
        for (int k = 0; k < 20; k++) drive_beat(k, {$urandom, $urandom});
        total++;
        if (beat_cnt !== 5'd20) $display("FAIL abort_mid_beat_cnt_before: got %0d want 20", beat_cnt);
        else passed++;
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = ~m2[4*64 +: 64];
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        total++;
        if (beat_cnt !== 5'd0) $display("FAIL abort_mid_beat_cnt: got %0d want 0", beat_cnt);
        else passed++;
        total++;
        if ({in1, in2} !== {m1, m2}) $display("FAIL abort_mid_operands: got in2[319:256]=%h want %h", in2[319:256], m2[319:256]);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if ({op_valid, res_valid, s_ready} !== 3'b001) $display("FAIL abort_mid_flags: got %b want 001", {op_valid, res_valid, s_ready});
        else passed++;
        send_txn(rnd(), rnd(), 1'b0);
        wait_res(n);
        total++;
        if (n !== 7) $display("FAIL abort_reload_latency: got %0d want 7", n);
        else passed++;
        t = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        g = {in1, in2};
        w = {t.a, t.b};
        total++;
        if (g !== w) begin
            d = diff_chunk(g, w);
            $display("FAIL abort_reload_operands: chunk %0d got %h want %h", d, g[d*64 +: 64], w[d*64 +: 64]);
        end else passed++;
        @(negedge clk);
    endtask

    task automatic test_abort_beat0();
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = ~m1[63:0];
        total++;
        if (s_ready !== 1'b1) $display("FAIL abort_beat0_s_ready: got %b want 1", s_ready);
        else passed++;
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        total++;
        if (beat_cnt !== 5'd0) $display("FAIL abort_beat0_beat_cnt: got %0d want 0", beat_cnt);
        else passed++;
        total++;
        if (in1[63:0] !== m1[63:0]) $display("FAIL abort_beat0_dropped: got %h want %h", in1[63:0], m1[63:0]);
        else passed++;
    endtask

    task automatic test_abort_hold();
        txn_t t;
        int seen = 0;
        send_txn(rnd(), rnd(), 1'b0);
        t = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if ({op_valid, res_valid, s_ready, beat_cnt} !== {3'b001, 5'd0}) $display("FAIL abort_hold_state: got %b want 00100000", {op_valid, res_valid, s_ready, beat_cnt});
        else passed++;
        total++;
        if ({in1, in2} !== {t.a, t.b}) $display("FAIL abort_hold_operands: got in1[63:0]=%h want %h", in1[63:0], t.a[63:0]);
        else passed++;
        repeat (10) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL abort_hold_no_res: got %0d res cycles want 0", seen);
        else passed++;
    endtask

    task automatic test_reset_hold();
        logic [2047:0] g, w;
        txn_t t;
        int seen = 0;
        int n, d;
        send_txn(rnd(), rnd(), 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({op_valid, res_valid, s_ready, beat_cnt} !== {3'b001, 5'd0}) $display("FAIL reset_hold_async_flags: got %b want 00100000", {op_valid, res_valid, s_ready, beat_cnt});
        else passed++;
        total++;
        if (in1 !== '0 || in2 !== '0) $display("FAIL reset_hold_async_operands: got in1[63:0]=%h in2[63:0]=%h want 0", in1[63:0], in2[63:0]);
        else passed++;
        void'(exp_q.pop_front());
        m1 = '0;
        m2 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (res_valid !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL reset_hold_no_res: got %0d res cycles want 0", seen);
        else passed++;
        send_txn(rnd(), rnd(), 1'b0);
        wait_res(n);
        total++;
        if (n !== 7) $display("FAIL post_reset_latency: got %0d want 7", n);
        else passed++;
        t = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        g = {in1, in2};
        w = {t.a, t.b};
        total++;
        if (g !== w) begin
            d = diff_chunk(g, w);
            $display("FAIL post_reset_operands: chunk %0d got %h want %h", d, g[d*64 +: 64], w[d*64 +: 64]);
        end else passed++;
        @(negedge clk);
    endtask

    task automatic test_hold1();
        logic [1023:0] a, b;
        logic [2047:0] g, w;
        txn_t t;
        int d;
        a = rnd();
        b = rnd();
        exp_q.push_back({a, b});
        for (int k = 0; k < 32; k++) begin
            s_valid_h1 = 1'b1;
            s_data_h1  = k < 16 ? a[k*64 +: 64] : b[(k-16)*64 +: 64];
            @(negedge clk);
        end
        s_data_h1 = ~a[63:0];
        total++;
        if ({op_valid_h1, res_valid_h1, s_ready_h1} !== 3'b100) $display("FAIL hold1_cycle1: got %b want 100", {op_valid_h1, res_valid_h1, s_ready_h1});
        else passed++;
        @(negedge clk);
        total++;
        if ({op_valid_h1, res_valid_h1, s_ready_h1} !== 3'b110) $display("FAIL hold1_cycle2: got %b want 110", {op_valid_h1, res_valid_h1, s_ready_h1});
        else passed++;
        t = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        w = {t.a, t.b};
        @(negedge clk);
        s_valid_h1 = 1'b0;
        total++;
        if ({op_valid_h1, res_valid_h1, s_ready_h1} !== 3'b001) $display("FAIL hold1_cycle3: got %b want 001", {op_valid_h1, res_valid_h1, s_ready_h1});
        else passed++;
        g = {in1_h1, in2_h1};
        total++;
        if (g !== w) begin
            d = diff_chunk(g, w);
            $display("FAIL hold1_operands: chunk %0d got %h want %h", d, g[d*64 +: 64], w[d*64 +: 64]);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_abort_mid_load();
        test_abort_beat0();
        test_abort_hold();
        test_reset_hold();
        test_hold1();
        total++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drained: got %0d left want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
